// File: rtl/spi_flash_master_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_master_if
// Brief    : Host-side strobe/data bus between the IO decode stage and the
//            configuration-flash SPI master.
// Revision : 1.0
// ============================================================================
interface spi_flash_master_if #(
    parameter int DATA_W = 8
);
    logic              wr_data;
    logic              wr_cs;
    logic              rd_data;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;

    modport master (
        output wr_data, wr_cs, rd_data, wd,
        input  rx_data, rx_valid, busy
    );

    modport slave (
        input  wr_data, wr_cs, rd_data, wd,
        output rx_data, rx_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/spi_flash_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_master
// Brief    : Byte-wide SPI master for the configuration flash (MSB first).
//            Default build is SPI mode 0; define SPI_MODE3_EN for SPI mode 3.
// Revision : 1.0
// ============================================================================
module spi_flash_master #(
    parameter int CLKDIV = 2,
    parameter int DATA_W = 8
) (
    input  wire logic          clk,
    input  wire logic          resetq,
    spi_flash_master_if.slave  bus,
    output logic               cs_n,
    output logic               sck,
    output logic               mosi,
    input  wire logic          miso
);

    generate
        if (DATA_W != 8) begin : g_bad_data_w
            $error("spi_flash_master: DATA_W must be 8");
        end
        if ((CLKDIV < 1) || (CLKDIV > 255)) begin : g_bad_clkdiv
            $error("spi_flash_master: CLKDIV must be in 1..255");
        end
    endgenerate

`ifdef SPI_MODE3_EN
    localparam logic IDLE_SCK       = 1'b1;
    localparam bit   SAMPLE_IN_LEAD = 1'b0;
`else
    localparam logic IDLE_SCK       = 1'b0;
    localparam bit   SAMPLE_IN_LEAD = 1'b1;
`endif

    localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEAD  = 2'd1,
        S_TRAIL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [7:0]        div_q;
    logic [2:0]        bit_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              busy_q;
    logic              cs_n_q;
    logic              sck_q;
    logic              mosi_q;
    logic              div_last;

    assign div_last = (div_q == DIV_LAST);

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q    <= S_IDLE;
            div_q      <= 8'd0;
            bit_q      <= 3'd0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            sck_q      <= IDLE_SCK;
            mosi_q     <= 1'b0;
        end else begin
            if (bus.rd_data) begin
                rx_valid_q <= 1'b0;
            end
            if (bus.wr_cs) begin
                cs_n_q <= ~bus.wd[0];
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.wr_data) begin
                        shift_q    <= bus.wd;
                        mosi_q     <= bus.wd[DATA_W-1];
                        bit_q      <= 3'd0;
                        div_q      <= 8'd0;
                        rx_valid_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_LEAD;
                    end
                end

                S_LEAD: begin
                    if (div_last) begin
                        div_q   <= 8'd0;
                        sck_q   <= ~IDLE_SCK;
                        state_q <= S_TRAIL;
                        if (SAMPLE_IN_LEAD) begin
                            shift_q <= {shift_q[DATA_W-2:0], miso};
                        end
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end

                S_TRAIL: begin
                    if (div_last) begin
                        div_q <= 8'd0;
                        sck_q <= IDLE_SCK;
                        if (!SAMPLE_IN_LEAD) begin
                            shift_q <= {shift_q[DATA_W-2:0], miso};
                        end
                        if (bit_q == 3'd7) begin
                            state_q <= S_DONE;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            state_q <= S_LEAD;
                            // Next MSB: mode 0 already shifted in LEAD, mode 3 shifts on this edge.
                            mosi_q  <= SAMPLE_IN_LEAD ? shift_q[DATA_W-1] : shift_q[DATA_W-2];
                        end
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end

                S_DONE: begin
                    rx_data_q  <= shift_q;
                    rx_valid_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.busy     = busy_q;
    assign cs_n         = cs_n_q;
    assign sck          = sck_q;
    assign mosi         = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_master
// Brief    : Scoreboard bench for spi_flash_master (loopback and flash model).
// Revision : 1.0
// ============================================================================
module tb_spi_flash_master;

    localparam int CLKDIV   = 2;
    localparam int SCK_PER  = 2 * CLKDIV;
    localparam int BUSY_CYC = 16 * CLKDIV + 1;
`ifdef SPI_MODE3_EN
    localparam logic IDLE_SCK = 1'b1;
`else
    localparam logic IDLE_SCK = 1'b0;
`endif

    typedef struct {
        logic [7:0] rx;
        logic [7:0] tx;
        int         pulses;
        int         busy_cyc;
    } exp_t;

    logic clk    = 1'b0;
    logic resetq = 1'b0;
    logic cs_n, sck, mosi, miso;

    logic       loopback   = 1'b1;
    logic [7:0] flash_byte = 8'h00;
    logic [3:0] rise_cnt   = 4'd0;
    logic [7:0] flash_sh;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    spi_flash_master_if bus_if ();

    spi_flash_master #(
        .CLKDIV (CLKDIV),
        .DATA_W (8)
    ) dut (
        .clk    (clk),
        .resetq (resetq),
        .bus    (bus_if),
        .cs_n   (cs_n),
        .sck    (sck),
        .mosi   (mosi),
        .miso   (miso)
    );

    always #5 clk = ~clk;

    // Flash model presents the next MSB after every sampling (rising) edge.
    assign flash_sh = flash_byte << rise_cnt;
    assign miso     = loopback ? mosi : flash_sh[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic       prev_sck   = IDLE_SCK;
    logic       prev_busy  = 1'b0;
    int         cyc        = 0;
    int         busy_cnt   = 0;
    int         pulse_cnt  = 0;
    int         last_edge  = 0;
    logic       spacing_ok = 1'b1;
    logic [7:0] mosi_cap   = 8'h00;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!resetq) begin
            prev_busy = 1'b0;
            prev_sck  = sck;
        end else begin
            if (bus_if.busy && !prev_busy) begin
                busy_cnt   = 0;
                pulse_cnt  = 0;
                mosi_cap   = 8'h00;
                spacing_ok = 1'b1;
                rise_cnt   = 4'd0;
            end
            if (bus_if.busy) busy_cnt++;
            if ((prev_sck == IDLE_SCK) && (sck != IDLE_SCK)) begin
                if ((pulse_cnt > 0) && ((cyc - last_edge) != SCK_PER)) spacing_ok = 1'b0;
                last_edge = cyc;
                pulse_cnt++;
                mosi_cap = {mosi_cap[6:0], mosi};
            end
            if (!prev_sck && sck && (rise_cnt < 4'd8)) rise_cnt = rise_cnt + 4'd1;
            if (prev_busy && !bus_if.busy) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_completion: got rx_data %0h with empty scoreboard", bus_if.rx_data);
                end else begin
                    e = sb_q.pop_front();
                    check("rx_data",    {24'h0, bus_if.rx_data}, {24'h0, e.rx});
                    check("rx_valid",   {31'h0, bus_if.rx_valid}, 32'h1);
                    check("sck_pulses", pulse_cnt, e.pulses);
                    check("busy_cycles", busy_cnt, e.busy_cyc);
                    check("sck_spacing", {31'h0, spacing_ok}, 32'h1);
                    check("mosi_bits",  {24'h0, mosi_cap}, {24'h0, e.tx});
                end
            end
            prev_busy = bus_if.busy;
            prev_sck  = sck;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [7:0] tx, input logic [7:0] rx_exp, input bit push);
        exp_t e;
        if (push) begin
            e.rx       = rx_exp;
            e.tx       = tx;
            e.pulses   = 8;
            e.busy_cyc = BUSY_CYC;
            sb_q.push_back(e);
        end
        bus_if.wd      = tx;
        bus_if.wr_data = 1'b1;
        tick();
        bus_if.wr_data = 1'b0;
    endtask

    task automatic select_flash();
        bus_if.wd    = 8'h01;
        bus_if.wr_cs = 1'b1;
        tick();
        bus_if.wr_cs = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((bus_if.busy !== 1'b0) && (n < 200)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_vec++;
            n_err++;
            $display("FAIL busy_timeout: busy still %0b after %0d cycles, required 0", bus_if.busy, n);
        end
        tick();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cs_n"},     {31'h0, cs_n}, 32'h1);
        check({tag, "_sck"},      {31'h0, sck}, {31'h0, IDLE_SCK});
        check({tag, "_mosi"},     {31'h0, mosi}, 32'h0);
        check({tag, "_busy"},     {31'h0, bus_if.busy}, 32'h0);
        check({tag, "_rx_valid"}, {31'h0, bus_if.rx_valid}, 32'h0);
        check({tag, "_rx_data"},  {24'h0, bus_if.rx_data}, 32'h0);
    endtask

    initial begin
        bus_if.wr_data = 1'b0;
        bus_if.wr_cs   = 1'b0;
        bus_if.rd_data = 1'b0;
        bus_if.wd      = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        tick();
        resetq = 1'b1;
        tick();

        select_flash();
        @(negedge clk);
        check("cs_select", {31'h0, cs_n}, 32'h0);
        tick();

        // Loopback A5
        loopback = 1'b1;
        start_xfer(8'hA5, 8'hA5, 1'b1);
        @(negedge clk);
        check("busy_after_wr", {31'h0, bus_if.busy}, 32'h1);
        wait_idle();
        check("cs_held", {31'h0, cs_n}, 32'h0);

        bus_if.rd_data = 1'b1;
        tick();
        bus_if.rd_data = 1'b0;
        @(negedge clk);
        check("rd_clears_valid", {31'h0, bus_if.rx_valid}, 32'h0);
        check("rd_keeps_data", {24'h0, bus_if.rx_data}, 32'hA5);
        tick();

        // Flash returns 3C while 9F goes out
        loopback   = 1'b0;
        flash_byte = 8'h3C;
        start_xfer(8'h9F, 8'h3C, 1'b1);
        wait_idle();

        // Second wr_data at cycle 10 is ignored
        loopback = 1'b1;
        start_xfer(8'h5A, 8'h5A, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        bus_if.wd      = 8'h00;
        bus_if.wr_data = 1'b1;
        tick();
        bus_if.wr_data = 1'b0;
        wait_idle();

        // rd_data coincident with DONE, then again one cycle later
        start_xfer(8'h96, 8'h96, 1'b1);
        repeat (32) @(posedge clk);
        #1;
        bus_if.rd_data = 1'b1;
        tick();
        @(negedge clk);
        check("rd_at_done_valid", {31'h0, bus_if.rx_valid}, 32'h1);
        tick();
        bus_if.rd_data = 1'b0;
        @(negedge clk);
        check("rd_after_done_valid", {31'h0, bus_if.rx_valid}, 32'h0);
        check("rd_after_done_data", {24'h0, bus_if.rx_data}, 32'h96);
        tick();

        // Reset at cycle 15 aborts the transfer
        start_xfer(8'h81, 8'h81, 1'b0);
        repeat (14) @(posedge clk);
        #1;
        resetq = 1'b0;
        #1;
        check_reset_values("abort");
        repeat (2) @(posedge clk);
        #1;
        resetq = 1'b1;
        tick();
        select_flash();
        tick();
        start_xfer(8'hC3, 8'hC3, 1'b1);
        wait_idle();

        tick();
        check("scoreboard_drained", sb_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
